// File: rtl/dsp_pkg.sv
// Shared constants for the sample-rate elastic buffers in the DSP chain.
package dsp_pkg;

  localparam int unsigned SRL_DEPTH = 128;
  localparam int unsigned SRL_AW    = 7;
  localparam int unsigned FIFO_W    = 8;
  // SRL entries plus the registered output stage.
  localparam int unsigned FIFO_CAP  = SRL_DEPTH + 1;
  localparam int unsigned LVL_W     = $clog2(FIFO_CAP + 1);

endpackage

// File: rtl/srl128x8e.sv
// 128-deep, 8-bit addressable shift register with clock enable.
// Newest entry sits at address 0; read port is asynchronous.
module srl128x8e
  import dsp_pkg::*;
(
  input  logic              clk,
  input  logic              ce,
  input  logic [SRL_AW-1:0] a,
  input  logic [FIFO_W-1:0] d,
  output logic [FIFO_W-1:0] q
);

  logic [FIFO_W-1:0] mem_q [SRL_DEPTH];

  // Shift in new data at tap 0 when enabled; storage is never reset.
  always_ff @(posedge clk) begin
    if (ce) begin
      mem_q[0] <= d;
      for (int i = 1; i < int'(SRL_DEPTH); i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  assign q = mem_q[a];

endmodule

// File: rtl/srl_fifo_ctl.sv
// First-word-fall-through FIFO sequencer around a single SRL128x8 with a
// registered valid/ready output stage.
module srl_fifo_ctl
  import dsp_pkg::*;
#(
  parameter int unsigned AF_LEVEL = 112,
  parameter int unsigned AE_LEVEL = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [FIFO_W-1:0] din,
  input  logic              wr_en,
  output logic              wr_rdy,
  output logic [FIFO_W-1:0] dout,
  output logic              dout_vld,
  input  logic              rd_en,
  output logic [LVL_W-1:0]  level,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              ovf,
  output logic              udf
);

  localparam logic [LVL_W:0]   AfLvl   = (LVL_W+1)'(AF_LEVEL);
  localparam logic [LVL_W:0]   AeLvl   = (LVL_W+1)'(AE_LEVEL);
  localparam logic [LVL_W-1:0] CntFull = LVL_W'(SRL_DEPTH);

  logic [LVL_W-1:0]  cnt_q, cnt_d;
  logic [FIFO_W-1:0] dout_q, dout_d;
  logic              dout_vld_q, dout_vld_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  logic              push, load;
  logic [SRL_AW-1:0] srl_a;
  logic [FIFO_W-1:0] srl_q;

  // Full is judged on registered count only: no write-through when full.
  assign wr_rdy = (cnt_q != CntFull);
  assign push   = wr_en && wr_rdy;
  assign load   = (cnt_q != '0) && (!dout_vld_q || rd_en);
  // Oldest entry; wraps to 127 when the SRL is full, don't-care when empty.
  assign srl_a  = cnt_q[SRL_AW-1:0] - SRL_AW'(1);

  srl128x8e u_srl (
    .clk (clk),
    .ce  (push),
    .a   (srl_a),
    .d   (din),
    .q   (srl_q)
  );

  // Next-state: occupancy, output stage and sticky error flags.
  always_comb begin
    cnt_d      = cnt_q + {{(LVL_W-1){1'b0}}, push} - {{(LVL_W-1){1'b0}}, load};
    dout_d     = load ? srl_q : dout_q;
    dout_vld_d = load ? 1'b1 : (rd_en ? 1'b0 : dout_vld_q);
    ovf_d      = ovf_q | (wr_en && !wr_rdy);
    udf_d      = udf_q | (rd_en && !dout_vld_q);
    if (flush) begin
      cnt_d      = '0;
      dout_vld_d = 1'b0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  assign dout         = dout_q;
  assign dout_vld     = dout_vld_q;
  assign ovf          = ovf_q;
  assign udf          = udf_q;
  assign level        = cnt_q + {{(LVL_W-1){1'b0}}, dout_vld_q};
  assign almost_full  = ({1'b0, level} >= AfLvl);
  assign almost_empty = ({1'b0, level} <= AeLvl);

endmodule

// File: tb/tb_srl_fifo_ctl.sv
// Scoreboard bench for srl_fifo_ctl: every cycle the model predicts the
// handshake, queue depth and flags; popped data is compared in order.
module tb_srl_fifo_ctl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] din = 8'h00;
  logic       wr_en = 1'b0;
  logic       wr_rdy;
  logic [7:0] dout;
  logic       dout_vld;
  logic       rd_en = 1'b0;
  logic [7:0] level;
  logic       almost_full;
  logic       almost_empty;
  logic       ovf;
  logic       udf;

  srl_fifo_ctl #(
    .AF_LEVEL (112),
    .AE_LEVEL (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .din          (din),
    .wr_en        (wr_en),
    .wr_rdy       (wr_rdy),
    .dout         (dout),
    .dout_vld     (dout_vld),
    .rd_en        (rd_en),
    .level        (level),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .ovf          (ovf),
    .udf          (udf)
  );

  always #5 clk = ~clk;

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;

  // Reference model state.
  logic [7:0] sb_q[$];
  int         m_cnt = 0;
  logic       m_vld = 1'b0;
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_state();
    check_val("level", 32'(level), 32'(sb_q.size()));
    check_val("dout_vld", 32'(dout_vld), 32'(m_vld));
    check_val("wr_rdy", 32'(wr_rdy), 32'(m_cnt != 128));
    check_val("almost_full", 32'(almost_full), 32'(sb_q.size() >= 112));
    check_val("almost_empty", 32'(almost_empty), 32'(sb_q.size() <= 8));
    check_val("ovf", 32'(ovf), 32'(m_ovf));
    check_val("udf", 32'(udf), 32'(m_udf));
    if (m_vld && sb_q.size() > 0) check_val("head", 32'(dout), 32'(sb_q[0]));
  endtask

  // One clock with the given inputs; model advances alongside the DUT.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    logic push, load, pop;
    push = w && (m_cnt != 128);
    load = (m_cnt != 0) && (!m_vld || r);
    pop  = r && m_vld;
    if (w && !push) m_ovf = 1'b1;
    if (r && !m_vld) m_udf = 1'b1;
    if (pop) begin
      check_val("pop_data", 32'(dout), 32'(sb_q[0]));
      void'(sb_q.pop_front());
    end
    if (push) sb_q.push_back(d);
    m_cnt = m_cnt + int'(push) - int'(load);
    m_vld = load ? 1'b1 : (r ? 1'b0 : m_vld);
    wr_en = w; din = d; rd_en = r;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    check_state();
  endtask

  task automatic do_reset(input logic w, input logic r);
    rst = 1'b1; wr_en = w; rd_en = r; din = 8'hEE;
    @(posedge clk); #1;
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    sb_q.delete();
    m_cnt = 0; m_vld = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    check_state();
    check_val("rst_dout", 32'(dout), 32'h0);
  endtask

  task automatic do_flush(input logic w, input logic [7:0] d, input logic r);
    if (w && m_cnt == 128) m_ovf = 1'b1;
    if (r && !m_vld) m_udf = 1'b1;
    flush = 1'b1; wr_en = w; din = d; rd_en = r;
    @(posedge clk); #1;
    flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    sb_q.delete();
    m_cnt = 0; m_vld = 1'b0;
    check_state();
  endtask

  initial begin
    // Reset state.
    do_reset(1'b0, 1'b0);
    check_val("rst_level", 32'(level), 32'd0);
    check_val("rst_ae", 32'(almost_empty), 32'd1);

    // Single write: accepted, then loaded into the output stage next edge.
    cyc(1'b1, 8'hA5, 1'b0);
    check_val("lat_vld0", 32'(dout_vld), 32'd0);
    check_val("lat_lvl0", 32'(level), 32'd1);
    cyc(1'b0, 8'h00, 1'b0);
    check_val("lat_vld1", 32'(dout_vld), 32'd1);
    check_val("lat_dout", 32'(dout), 32'hA5);
    check_val("lat_lvl1", 32'(level), 32'd1);
    cyc(1'b0, 8'h00, 1'b1);

    // Fill to capacity, overflow, then drain in order.
    for (int i = 0; i < 129; i++) cyc(1'b1, 8'(i), 1'b0);
    check_val("full_level", 32'(level), 32'd129);
    check_val("full_rdy", 32'(wr_rdy), 32'd0);
    check_val("full_af", 32'(almost_full), 32'd1);
    cyc(1'b1, 8'hFF, 1'b0);
    check_val("full_ovf", 32'(ovf), 32'd1);
    for (int i = 0; i < 129; i++) cyc(1'b0, 8'h00, 1'b1);
    check_val("drain_level", 32'(level), 32'd0);
    cyc(1'b0, 8'h00, 1'b1);
    check_val("udf_set", 32'(udf), 32'd1);

    // Full with simultaneous write and read: write rejected, read completes.
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 129; i++) cyc(1'b1, 8'(i + 7), 1'b0);
    cyc(1'b1, 8'h55, 1'b1);
    check_val("fr_ovf", 32'(ovf), 32'd1);
    check_val("fr_rdy", 32'(wr_rdy), 32'd1);
    check_val("fr_level", 32'(level), 32'd128);

    // Streaming: continuous writes, reads whenever data is presented.
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 200; i++) cyc(1'b1, 8'(i * 3), dout_vld);
    check_val("stream_ovf", 32'(ovf), 32'd0);
    check_val("stream_udf", 32'(udf), 32'd0);

    // Flush at level 50 with a simultaneous write.
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 50; i++) cyc(1'b1, 8'(i), 1'b0);
    check_val("pre_flush_lvl", 32'(level), 32'd50);
    do_flush(1'b1, 8'h99, 1'b0);
    check_val("flush_level", 32'(level), 32'd0);
    check_val("flush_vld", 32'(dout_vld), 32'd0);
    cyc(1'b1, 8'h3C, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    check_val("post_flush_dout", 32'(dout), 32'h3C);

    // Reset mid-fill with traffic in flight.
    for (int i = 0; i < 20; i++) cyc(1'b1, 8'(i), 1'b0);
    do_reset(1'b1, 1'b1);

    // Random traffic.
    for (int i = 0; i < 10000; i++) begin
      cyc(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 50));
    end
    for (int i = 0; i < 140; i++) cyc(1'b0, 8'h00, dout_vld);
    check_val("final_level", 32'(level), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
